// File: rtl/mux_rr.sv
// ---------------------------------------------------------------------------
// mux_rr
//
// Purpose:
//   N-to-1 channel multiplexer with a single registered output stage.
//   It picks one input channel per cycle and moves that channel's data into
//   the output register. The channel can be chosen in one of two ways:
//     - fixed select: the channel named by 'sel' (mode = 0)
//     - round-robin: the next valid channel after the last one granted
//       (mode = 1)
//   The output register drains while it is filling, so the block moves one
//   beat per cycle when downstream is always ready.
//
// Parameters:
//   WIDTH   data width per channel (1..64)
//   NUM_IN  number of input channels (2..16)
//
// Ports:
//   clk        in   clock; all state changes on the rising edge
//   rst_n      in   asynchronous active-low reset
//   mode       in   0 = fixed select by sel, 1 = round-robin
//   sel        in   channel index used when mode = 0
//   in_data    in   flattened channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid   in   per-channel valid
//   in_ready   out  per-channel ready (combinational, at most one bit set)
//   out_data   out  registered output data
//   out_valid  out  registered output valid
//   out_ready  in   downstream ready
//   out_src    out  registered index of the channel held in out_data
// ---------------------------------------------------------------------------
module mux_rr #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_src
);

    // Output stage and round-robin state
    logic [WIDTH-1:0] r_outData;
    logic             r_outValid;
    logic [SEL_W-1:0] r_outSrc;
    logic [SEL_W-1:0] r_ptr;

    // Candidate selection
    logic             w_loadEn;
    logic             w_found;
    logic [SEL_W-1:0] w_cand;
    logic [WIDTH-1:0] w_candData;
    logic             w_xfer;
    int               w_scanIdx;

    // The output register may take a new beat whenever it is empty or its
    // current beat is being consumed on this same edge.
    assign w_loadEn = !r_outValid || out_ready;

    // Candidate search. In fixed mode the comparison against each in-range
    // index keeps an out-of-range sel from ever matching. In round-robin mode
    // the scan starts one past the pointer and wraps with a subtraction rather
    // than a bit-mask, so non-power-of-two channel counts never step past
    // NUM_IN-1.
    always_comb begin
        w_found   = 1'b0;
        w_cand    = '0;
        w_scanIdx = 0;
        if (mode) begin
            for (int k = 1; k <= NUM_IN; k++) begin
                w_scanIdx = int'(r_ptr) + k;
                if (w_scanIdx >= NUM_IN) begin
                    w_scanIdx = w_scanIdx - NUM_IN;
                end
                if (w_scanIdx >= NUM_IN) begin
                    w_scanIdx = w_scanIdx - NUM_IN;
                end
                if (!w_found && in_valid[w_scanIdx]) begin
                    w_found = 1'b1;
                    w_cand  = SEL_W'(w_scanIdx);
                end
            end
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (sel == SEL_W'(i) && in_valid[i]) begin
                    w_found = 1'b1;
                    w_cand  = SEL_W'(i);
                end
            end
        end
    end

    // Data of the selected channel. w_cand is always a legal index because it
    // is only ever set from an in-range loop value, and it is zero otherwise.
    assign w_candData = in_data[int'(w_cand)*WIDTH +: WIDTH];

    // The candidate is valid by construction, so a transfer happens whenever
    // the output stage can load and a candidate exists.
    assign w_xfer = w_loadEn && w_found;

    // One-hot ready toward the selected channel. rst_n gates it so that no
    // upstream source believes a beat was taken while the block is in reset.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (rst_n && w_xfer && (w_cand == SEL_W'(i))) begin
                in_ready[i] = 1'b1;
            end
        end
    end

    // Output register. A transfer loads the new beat, even when the old beat
    // is leaving on the same edge, so there is no bubble. If the stage could
    // load but nothing was offered, only valid drops. Data and source stay as
    // they were, so the last value remains visible for debugging. While
    // stalled, everything holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outData  <= '0;
            r_outValid <= 1'b0;
            r_outSrc   <= '0;
        end else if (w_xfer) begin
            r_outData  <= w_candData;
            r_outValid <= 1'b1;
            r_outSrc   <= w_cand;
        end else if (w_loadEn) begin
            r_outValid <= 1'b0;
        end
    end

    // Round-robin pointer. It remembers the last channel granted in
    // round-robin mode. Fixed-mode traffic leaves it alone, so switching back
    // to round-robin continues the rotation where it stopped. The reset value
    // is the highest index, which makes the first scan start at channel 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= SEL_W'(NUM_IN - 1);
        end else if (w_xfer && mode) begin
            r_ptr <= w_cand;
        end
    end

    assign out_data  = r_outData;
    assign out_valid = r_outValid;
    assign out_src   = r_outSrc;

endmodule

// File: tb/tb_mux_rr.sv
// ---------------------------------------------------------------------------
// tb_mux_rr
//
// Directed testbench for mux_rr. Two instances share the clock and reset:
//   u_dut4: WIDTH=32, NUM_IN=4 (main scenarios)
//   u_dut3: WIDTH=32, NUM_IN=3 (out-of-range select and wrap on a
//           non-power-of-two channel count)
// Each scenario task drives its own stimulus and compares against
// hand-computed values.
// ---------------------------------------------------------------------------
module tb_mux_rr;

    logic         clk;
    logic         rst_n;

    // Four-channel instance signals
    logic         mode;
    logic [1:0]   sel;
    logic [127:0] in_data;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   out_src;

    // Three-channel instance signals
    logic         mode3;
    logic [1:0]   sel3;
    logic [95:0]  in_data3;
    logic [2:0]   in_valid3;
    logic [2:0]   in_ready3;
    logic [31:0]  out_data3;
    logic         out_valid3;
    logic         out_ready3;
    logic [1:0]   out_src3;

    int testsRun    = 0;
    int testsFailed = 0;

    mux_rr #(.WIDTH(32), .NUM_IN(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_src   (out_src)
    );

    mux_rr #(.WIDTH(32), .NUM_IN(3)) u_dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode3),
        .sel       (sel3),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .out_data  (out_data3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .out_src   (out_src3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge. Inputs are driven and outputs are
    // sampled 1 time unit after the edge.
    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    // Check the asynchronous reset values before any clock edge.
    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        testsRun++;
        if (out_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_valid got=%0b exp=0", out_valid);
        end
        testsRun++;
        if (out_data !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_data got=%h exp=0", out_data);
        end
        testsRun++;
        if (out_src !== 2'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_src got=%0d exp=0", out_src);
        end
        in_valid = 4'b1111;
        #1;
        testsRun++;
        if (in_ready !== 4'b0000) begin
            testsFailed++;
            $display("[TB] FAIL reset_ready got=%b exp=0000", in_ready);
        end
        in_valid = 4'b0000;
        stepClock();
        rst_n = 1'b1;
        stepClock();
    endtask

    // Fixed select of channel 2.
    task automatic test_fixed();
        mode      = 1'b0;
        sel       = 2'd2;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #1;
        testsRun++;
        if (in_ready !== 4'b0100) begin
            testsFailed++;
            $display("[TB] FAIL fixed_ready got=%b exp=0100", in_ready);
        end
        stepClock();
        in_valid = 4'b0000;
        testsRun++;
        if (out_data !== 32'hCAFE_0002) begin
            testsFailed++;
            $display("[TB] FAIL fixed_data got=%h exp=cafe0002", out_data);
        end
        testsRun++;
        if (out_src !== 2'd2) begin
            testsFailed++;
            $display("[TB] FAIL fixed_src got=%0d exp=2", out_src);
        end
        testsRun++;
        if (out_valid !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL fixed_valid got=%0b exp=1", out_valid);
        end
        stepClock();
    endtask

    // Round-robin from a fresh reset: grants must go 0,1,2,3,0,1,2,3 with a
    // new beat on every edge.
    task automatic test_round_robin();
        logic [1:0] expSrc;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        stepClock();
        mode      = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            expSrc = 2'(c % 4);
            #1;
            testsRun++;
            if (in_ready !== (4'b0001 << expSrc)) begin
                testsFailed++;
                $display("[TB] FAIL rr_ready[%0d] got=%b exp=%b", c, in_ready, 4'b0001 << expSrc);
            end
            stepClock();
            testsRun++;
            if (out_src !== expSrc || out_valid !== 1'b1 || out_data !== (32'hCAFE_0000 | 32'(expSrc))) begin
                testsFailed++;
                $display("[TB] FAIL rr_beat[%0d] got src=%0d v=%0b d=%h exp src=%0d v=1", c, out_src, out_valid, out_data, expSrc);
            end
        end
        in_valid = 4'b0000;
    endtask

    // Backpressure after round-robin (pointer now 3). Load channel 0, stall
    // for three cycles while the input data changes, then release. Channel 1
    // must load on that same edge.
    task automatic test_backpressure();
        in_valid  = 4'b0011;
        out_ready = 1'b1;
        stepClock();
        testsRun++;
        if (out_src !== 2'd0 || out_valid !== 1'b1 || out_data !== 32'hCAFE_0000) begin
            testsFailed++;
            $display("[TB] FAIL bp_load got src=%0d v=%0b d=%h exp src=0 v=1 d=cafe0000", out_src, out_valid, out_data);
        end
        out_ready = 1'b0;
        in_data[31:0] = 32'hDEAD_BEEF;
        for (int c = 0; c < 3; c++) begin
            #1;
            testsRun++;
            if (in_ready !== 4'b0000) begin
                testsFailed++;
                $display("[TB] FAIL bp_ready[%0d] got=%b exp=0000", c, in_ready);
            end
            stepClock();
            testsRun++;
            if (out_data !== 32'hCAFE_0000 || out_src !== 2'd0 || out_valid !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL bp_hold[%0d] got src=%0d v=%0b d=%h exp src=0 v=1 d=cafe0000", c, out_src, out_valid, out_data);
            end
        end
        in_data[31:0] = 32'hCAFE_0000;
        out_ready = 1'b1;
        #1;
        testsRun++;
        if (in_ready !== 4'b0010) begin
            testsFailed++;
            $display("[TB] FAIL bp_release_ready got=%b exp=0010", in_ready);
        end
        stepClock();
        testsRun++;
        if (out_src !== 2'd1 || out_valid !== 1'b1 || out_data !== 32'hCAFE_0001) begin
            testsFailed++;
            $display("[TB] FAIL bp_release got src=%0d v=%0b d=%h exp src=1 v=1 d=cafe0001", out_src, out_valid, out_data);
        end
    endtask

    // Sparse round-robin with the pointer at 1. The scan must skip idle
    // channels and then wrap back to 0. After that, an empty cycle drops
    // valid and leaves data and source unchanged.
    task automatic test_sparse();
        mode      = 1'b1;
        out_ready = 1'b1;
        in_valid  = 4'b1001;
        #1;
        testsRun++;
        if (in_ready !== 4'b1000) begin
            testsFailed++;
            $display("[TB] FAIL sparse_ready1 got=%b exp=1000", in_ready);
        end
        stepClock();
        testsRun++;
        if (out_src !== 2'd3 || out_data !== 32'hCAFE_0003) begin
            testsFailed++;
            $display("[TB] FAIL sparse_grant1 got src=%0d d=%h exp src=3 d=cafe0003", out_src, out_data);
        end
        #1;
        testsRun++;
        if (in_ready !== 4'b0001) begin
            testsFailed++;
            $display("[TB] FAIL sparse_ready2 got=%b exp=0001", in_ready);
        end
        stepClock();
        testsRun++;
        if (out_src !== 2'd0 || out_data !== 32'hCAFE_0000) begin
            testsFailed++;
            $display("[TB] FAIL sparse_wrap got src=%0d d=%h exp src=0 d=cafe0000", out_src, out_data);
        end
        in_valid = 4'b0000;
        stepClock();
        testsRun++;
        if (out_valid !== 1'b0 || out_src !== 2'd0 || out_data !== 32'hCAFE_0000) begin
            testsFailed++;
            $display("[TB] FAIL idle_drop got v=%0b src=%0d d=%h exp v=0 src=0 d=cafe0000", out_valid, out_src, out_data);
        end
    endtask

    // Assert reset between edges while a beat is held. The outputs must clear
    // right away. After reset, the first round-robin grant must go to the
    // lowest-index valid channel.
    task automatic test_reset_mid();
        mode      = 1'b0;
        sel       = 2'd1;
        in_valid  = 4'b0010;
        out_ready = 1'b1;
        stepClock();
        in_valid  = 4'b0000;
        out_ready = 1'b0;
        testsRun++;
        if (out_valid !== 1'b1 || out_src !== 2'd1) begin
            testsFailed++;
            $display("[TB] FAIL midrst_setup got v=%0b src=%0d exp v=1 src=1", out_valid, out_src);
        end
        #2;
        rst_n = 1'b0;
        #1;
        testsRun++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_src !== 2'd0) begin
            testsFailed++;
            $display("[TB] FAIL midrst_clear got v=%0b src=%0d d=%h exp all 0", out_valid, out_src, out_data);
        end
        stepClock();
        rst_n = 1'b1;
        mode      = 1'b1;
        in_valid  = 4'b0110;
        out_ready = 1'b1;
        #1;
        testsRun++;
        if (in_ready !== 4'b0010) begin
            testsFailed++;
            $display("[TB] FAIL postrst_ready got=%b exp=0010", in_ready);
        end
        stepClock();
        in_valid = 4'b0000;
        testsRun++;
        if (out_src !== 2'd1 || out_valid !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL postrst_grant got src=%0d v=%0b exp src=1 v=1", out_src, out_valid);
        end
    endtask

    // Three-channel instance. sel=3 is out of range, so it grants nothing.
    // Round-robin from the reset pointer (2) must then cycle 0,1,2,0.
    task automatic test_invalid_sel();
        logic [1:0] expSrc;
        mode3      = 1'b0;
        sel3       = 2'd0;
        in_valid3  = 3'b111;
        out_ready3 = 1'b1;
        stepClock();
        testsRun++;
        if (out_valid3 !== 1'b1 || out_src3 !== 2'd0 || out_data3 !== 32'hBEEF_0000) begin
            testsFailed++;
            $display("[TB] FAIL n3_load got v=%0b src=%0d d=%h exp v=1 src=0 d=beef0000", out_valid3, out_src3, out_data3);
        end
        sel3 = 2'd3;
        #1;
        testsRun++;
        if (in_ready3 !== 3'b000) begin
            testsFailed++;
            $display("[TB] FAIL n3_badsel_ready got=%b exp=000", in_ready3);
        end
        stepClock();
        testsRun++;
        if (out_valid3 !== 1'b0 || out_src3 !== 2'd0) begin
            testsFailed++;
            $display("[TB] FAIL n3_badsel_drop got v=%0b src=%0d exp v=0 src=0", out_valid3, out_src3);
        end
        mode3 = 1'b1;
        for (int c = 0; c < 4; c++) begin
            expSrc = 2'(c % 3);
            stepClock();
            testsRun++;
            if (out_src3 !== expSrc || out_valid3 !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL n3_rr[%0d] got src=%0d v=%0b exp src=%0d v=1", c, out_src3, out_valid3, expSrc);
            end
        end
        in_valid3 = 3'b000;
    endtask

    initial begin
        rst_n      = 1'b0;
        mode       = 1'b0;
        sel        = 2'd0;
        in_valid   = 4'b0000;
        out_ready  = 1'b0;
        mode3      = 1'b0;
        sel3       = 2'd0;
        in_valid3  = 3'b000;
        out_ready3 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_data[i*32 +: 32] = 32'hCAFE_0000 | 32'(i);
        end
        for (int i = 0; i < 3; i++) begin
            in_data3[i*32 +: 32] = 32'hBEEF_0000 | 32'(i);
        end

        test_reset();
        test_fixed();
        test_round_robin();
        test_backpressure();
        test_sparse();
        test_reset_mid();
        test_invalid_sel();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
